// File: rtl/sync_fifo_if.sv
// Handshake bundle between a sync_fifo and its producer/consumer.
// The overflow/underflow wires exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if #(
  parameter int DATA_W = 4
);
   logic [DATA_W-1:0] data_in;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] data_out;
   logic              full;
   logic              empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic              overflow;
   logic              underflow;
`endif

   modport master (
      output data_in, wr_en, rd_en,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      input  overflow, underflow,
`endif
      input  data_out, full, empty
   );

   modport slave (
      input  data_in, wr_en, rd_en,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      output overflow, underflow,
`endif
      output data_out, full, empty
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port and registered full/empty flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add one-cycle overflow/underflow pulses.
module sync_fifo #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic        clk,
   input  logic        rst,
   sync_fifo_if.slave  bus
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              full_q, full_d, empty_q, empty_d;
   logic              wr_acc, rd_acc;

   // Both transfers are qualified on the pre-edge flags, so a simultaneous
   // read and write on an empty FIFO never forwards the write to data_out.
   always_comb begin
      wr_acc   = bus.wr_en & ~full_q;
      rd_acc   = bus.rd_en & ~empty_q;
      wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
      rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc};
      dout_d   = dout_q;
      if (rd_acc) dout_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
      empty_d  = (wr_ptr_d == rd_ptr_d);
      full_d   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                 (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (rst && wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.data_in;
   end

   assign bus.data_out = dout_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic ovf_q, unf_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= bus.wr_en & full_q;
         unf_q <= bus.rd_en & empty_q;
      end
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a queue-based model.
module tb_sync_fifo;
   localparam int DATA_W = 4;
   localparam int DEPTH  = 16;

   logic clk = 1'b0;
   logic rst;
   sync_fifo_if #(.DATA_W(DATA_W)) bus();

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nfail = 0;
   bit go = 1'b0;

   // Model: a queue of stored words plus the last word read out.
   logic [DATA_W-1:0] q[$];
   logic [DATA_W-1:0] exp_dout = '0;
   logic              exp_ovf  = 1'b0;
   logic              exp_unf  = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         exp_dout <= '0;
         exp_ovf  <= 1'b0;
         exp_unf  <= 1'b0;
      end else begin
         exp_ovf <= bus.wr_en && (q.size() == DEPTH);
         exp_unf <= bus.rd_en && (q.size() == 0);
         if (bus.rd_en && q.size() != 0) begin
            exp_dout <= q.pop_front();
            // pre-edge occupancy was size()+1; write only if it was not full
            if (bus.wr_en && q.size() != DEPTH - 1) q.push_back(bus.data_in);
         end else if (bus.wr_en && q.size() != DEPTH) begin
            q.push_back(bus.data_in);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (go) begin
         chk("cmp_empty", int'(bus.empty), int'(q.size() == 0));
         chk("cmp_full",  int'(bus.full),  int'(q.size() == DEPTH));
         chk("cmp_dout",  int'(bus.data_out), int'(exp_dout));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
         chk("cmp_ovf", int'(bus.overflow),  int'(exp_ovf));
         chk("cmp_unf", int'(bus.underflow), int'(exp_unf));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wp, rp;
      rst = 1'b0;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b0;
      bus.data_in = '0;
      tick();
      go = 1'b1;
      // Held in reset with a write request pending
      repeat (3) tick();
      chk("rst_empty", int'(bus.empty), 1);
      chk("rst_full",  int'(bus.full), 0);
      chk("rst_dout",  int'(bus.data_out), 0);

      // Fill with 1..15,0
      rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.data_in = 4'((i + 1) % 16);
         tick();
         if (i == 0) chk("fill_empty_fall", int'(bus.empty), 0);
         if (i < DEPTH - 1) chk("fill_not_full", int'(bus.full), 0);
      end
      chk("fill_full", int'(bus.full), 1);

      // Write into a full FIFO is dropped
      bus.data_in = 4'd5;
      tick();
      chk("drop_full", int'(bus.full), 1);
      bus.wr_en = 1'b0;

      // Drain
      bus.rd_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         chk("drain_dout", int'(bus.data_out), (i + 1) % 16);
      end
      chk("drain_empty", int'(bus.empty), 1);
      repeat (2) tick();
      chk("underrun_dout", int'(bus.data_out), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("underrun_flag", int'(bus.underflow), 1);
`endif
      bus.rd_en = 1'b0;

      // Reset mid-stream discards stored words
      bus.wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.data_in = 4'(7 + i);
         tick();
      end
      bus.wr_en = 1'b0;
      rst = 1'b0;
      #1;
      chk("async_rst_empty", int'(bus.empty), 1);
      tick();
      rst = 1'b1;
      bus.wr_en = 1'b1;
      bus.data_in = 4'd5;
      tick();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b1;
      tick();
      chk("post_rst_dout", int'(bus.data_out), 5);
      chk("post_rst_empty", int'(bus.empty), 1);
      bus.rd_en = 1'b0;

      // Occupancy 1 with simultaneous read/write streaming
      bus.wr_en = 1'b1;
      bus.data_in = 4'd3;
      tick();
      bus.rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.data_in = 4'(6 + i);
         tick();
         chk("stream_dout", int'(bus.data_out), (i == 0) ? 3 : 6 + i - 1);
         chk("stream_empty", int'(bus.empty), 0);
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;

      // Random traffic in phases with varying write/read bias
      for (int ph = 0; ph < 8; ph++) begin
         wp = $urandom_range(10, 90);
         rp = $urandom_range(10, 90);
         for (int c = 0; c < 400; c++) begin
            bus.wr_en   = ($urandom_range(0, 99) < wp);
            bus.rd_en   = ($urandom_range(0, 99) < rp);
            bus.data_in = 4'($urandom);
            if ($urandom_range(0, 299) == 0) begin
               rst = 1'b0;
               tick();
               rst = 1'b1;
            end else begin
               tick();
            end
         end
      end

      go = 1'b0;
      $display("[TB] %0d tests run, %0d failed", nchk, nfail);
      $finish;
   end
endmodule
